// File: rtl/pc_pkg.sv
// Shared types, default vectors and the branch-target helper for the MIPS32 program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_INC,
        NPC_BR,
        NPC_J,
        NPC_JR,
        NPC_RAS,
        NPC_EXC,
        NPC_HOLD
    } npc_sel_e;

    localparam int          DEF_ADDR_W     = 10;
    localparam int unsigned DEF_RESET_VEC  = 32'h0000_0000;
    localparam int unsigned DEF_EXC_VEC    = 32'h0000_03F0;
    localparam int          DEF_RAS_DEPTH  = 4;
    localparam int          DEF_IMEM_WORDS = 1024;

    // Adds a sign-extended 16-bit word offset to a base; the caller truncates to its PC width.
    function automatic logic [31:0] br_target(input logic [31:0] base, input logic [15:0] off);
        return base + {{16{off[15]}}, off};
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, push+pop (replace top) and clear, with sticky
// overflow/underflow flags that only reset can clear.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top_ptr, top_ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              ovf_nxt, unf_nxt, wr_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign top   = mem[top_ptr];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        top_ptr_nxt = top_ptr;
        count_nxt   = count;
        ovf_nxt     = ovf;
        unf_nxt     = unf;
        wr_en       = 1'b0;
        wr_ptr      = top_ptr + 1'b1;

        if (clear) begin
            count_nxt = '0;
        end else if (push && pop) begin
            if (empty) begin
                // Return with nothing stacked still records the call's return address.
                unf_nxt     = 1'b1;
                wr_en       = 1'b1;
                top_ptr_nxt = wr_ptr;
                count_nxt   = CNT_W'(1);
            end else begin
                wr_en  = 1'b1;
                wr_ptr = top_ptr;
            end
        end else if (push) begin
            // When full the slot after top is the oldest entry, so it is simply overwritten.
            wr_en       = 1'b1;
            top_ptr_nxt = wr_ptr;
            if (full) begin
                ovf_nxt = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                unf_nxt = 1'b1;
            end else begin
                top_ptr_nxt = top_ptr - 1'b1;
                count_nxt   = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            top_ptr <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            top_ptr <= top_ptr_nxt;
            count   <= count_nxt;
            ovf     <= ovf_nxt;
            unf     <= unf_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read while count says it is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority mux, PC register and return-address stack.
// Optional fetch-range check enabled by defining PC_BOUNDS_CHECK_EN (adds the bound_err port).
module pc_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int unsigned RESET_VEC  = DEF_RESET_VEC,
    parameter int unsigned EXC_VEC    = DEF_EXC_VEC,
    parameter int          RAS_DEPTH  = DEF_RAS_DEPTH,
    parameter int          IMEM_WORDS = DEF_IMEM_WORDS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_tgt,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_tgt,
    input  logic              call,
    input  logic              ret,
    input  logic              exc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
`ifdef PC_BOUNDS_CHECK_EN
    ,
    output logic              bound_err
`endif
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("pc_unit: RAS_DEPTH must be a power of two >= 2");
    end
    if (IMEM_WORDS < 1) begin : g_bad_imem_words
        $error("pc_unit: IMEM_WORDS must be at least 1");
    end

    npc_sel_e          sel;
    logic [ADDR_W-1:0] npc_raw, npc, ras_top;
    logic              ras_push, ras_pop;

    assign pc_plus1 = pc + 1'b1;

    // Calls and returns are only honoured on cycles that actually advance the PC.
    assign ras_push = call && !exc && !stall;
    assign ras_pop  = jr && ret && !exc && !stall;

    always_comb begin
        sel = NPC_INC;
        if (exc)                          sel = NPC_EXC;
        else if (stall)                   sel = NPC_HOLD;
        else if (jr && ret && !ras_empty) sel = NPC_RAS;
        else if (jr)                      sel = NPC_JR;
        else if (jump)                    sel = NPC_J;
        else if (branch_taken)            sel = NPC_BR;
    end

    always_comb begin
        npc_raw = pc_plus1;
        case (sel)
            NPC_EXC:  npc_raw = EXC_PC;
            NPC_HOLD: npc_raw = pc;
            NPC_RAS:  npc_raw = ras_top;
            NPC_JR:   npc_raw = jr_tgt;
            NPC_J:    npc_raw = jump_tgt;
            NPC_BR:   npc_raw = ADDR_W'(br_target(32'(pc_plus1), branch_off));
            default:  npc_raw = pc_plus1;
        endcase
    end

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic [31:0] IMEM_LIM = 32'(IMEM_WORDS);

    logic out_of_range;

    // The exception vector itself is exempt so the redirect cannot loop on its own target.
    assign out_of_range = (32'(npc_raw) >= IMEM_LIM) && (npc_raw != EXC_PC);
    assign npc          = out_of_range ? EXC_PC : npc_raw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bound_err <= 1'b0;
        end else begin
            bound_err <= out_of_range;
        end
    end
`else
    assign npc = npc_raw;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RST_PC;
        end else begin
            pc <= npc;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rstn      (rstn),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (exc),
        .push_data (pc_plus1),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a
// queue-based reference model. Also builds with PC_BOUNDS_CHECK_EN defined.
module tb_pc_unit;

    localparam int ADDR_W    = 10;
    localparam int AMASK     = (1 << ADDR_W) - 1;
    localparam int RESET_VEC = 0;
    localparam int EXC_VEC   = 'h3F0;
    localparam int RAS_DEPTH = 4;
`ifdef PC_BOUNDS_CHECK_EN
    localparam int IMEM_WORDS = 512;
`else
    localparam int IMEM_WORDS = 1024;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              stall, branch_taken, jump, jr, call, ret, exc;
    logic [15:0]       branch_off;
    logic [ADDR_W-1:0] jump_tgt, jr_tgt;
    logic [ADDR_W-1:0] pc, pc_plus1;
    logic              ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_BOUNDS_CHECK_EN
    logic              bound_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pc;
    int m_ras[$];
    bit m_ovf, m_unf, m_berr;

    always #5 clk = ~clk;

    pc_unit #(
        .ADDR_W     (ADDR_W),
        .RESET_VEC  (RESET_VEC),
        .EXC_VEC    (EXC_VEC),
        .RAS_DEPTH  (RAS_DEPTH),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .jump_tgt     (jump_tgt),
        .jr           (jr),
        .jr_tgt       (jr_tgt),
        .call         (call),
        .ret          (ret),
        .exc          (exc),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_ovf      (ras_ovf),
        .ras_unf      (ras_unf)
`ifdef PC_BOUNDS_CHECK_EN
        ,
        .bound_err    (bound_err)
`endif
    );

    task automatic model_reset();
        m_pc = RESET_VEC;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_berr = 1'b0;
    endtask

    // One clock of architectural behaviour, computed from the current input values.
    task automatic model_step();
        int ppl;
        int npc;
        int off;
        ppl = (m_pc + 1) & AMASK;
        off = int'($signed(branch_off));
        m_berr = 1'b0;
        if (exc) begin
            npc = EXC_VEC;
            m_ras.delete();
        end else if (stall) begin
            npc = m_pc;
        end else begin
            if (jr && ret) begin
                if (m_ras.size() > 0) begin
                    npc = m_ras.pop_back();
                end else begin
                    npc = int'(jr_tgt);
                    m_unf = 1'b1;
                end
            end else if (jr)           npc = int'(jr_tgt);
            else if (jump)             npc = int'(jump_tgt);
            else if (branch_taken)     npc = (ppl + off) & AMASK;
            else                       npc = ppl;
            if (call) begin
                m_ras.push_back(ppl);
                if (m_ras.size() > RAS_DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end
        end
`ifdef PC_BOUNDS_CHECK_EN
        if (npc >= IMEM_WORDS && npc != EXC_VEC) begin
            npc = EXC_VEC;
            m_berr = 1'b1;
        end
`endif
        m_pc = npc;
    endtask

    task automatic drive(input bit s, input bit br, input logic [15:0] off, input bit j,
                         input int jt, input bit r_jr, input int jrt, input bit c,
                         input bit r, input bit e);
        stall        = s;
        branch_taken = br;
        branch_off   = off;
        jump         = j;
        jump_tgt     = ADDR_W'(jt);
        jr           = r_jr;
        jr_tgt       = ADDR_W'(jrt);
        call         = c;
        ret          = r;
        exc          = e;
    endtask

    task automatic idle_inputs();
        drive(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if (pc !== ADDR_W'(RESET_VEC)) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, ADDR_W'(RESET_VEC));
        end
        n_checks++;
        if (pc_plus1 !== ADDR_W'(RESET_VEC + 1)) begin
            n_fail++; $display("FAIL reset_pc_plus1: got %h expected %h", pc_plus1, ADDR_W'(RESET_VEC + 1));
        end
        n_checks++;
        if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ras_flags: got %b expected 1000",
                               {ras_empty, ras_full, ras_ovf, ras_unf});
        end
`ifdef PC_BOUNDS_CHECK_EN
        n_checks++;
        if (bound_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_bound_err: got %b expected 0", bound_err);
        end
`endif
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_free_run_stall();
        int exp_seq[7] = '{1, 2, 3, 4, 4, 4, 5};
        for (int i = 0; i < 7; i++) begin
            if (i == 4 || i == 5) drive(1, 1, 16'h0007, 1, 'h155, 0, 0, 1, 0, 0);
            else idle_inputs();
            tick();
            n_checks++;
            if (pc !== ADDR_W'(exp_seq[i])) begin
                n_fail++; $display("FAIL free_run_stall[%0d]: got %h expected %h", i, pc, ADDR_W'(exp_seq[i]));
            end
        end
        n_checks++;
        if (ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL stall_ignores_call: ras_empty got %b expected 1", ras_empty);
        end
    endtask

    task automatic test_wrap_branch();
`ifndef PC_BOUNDS_CHECK_EN
        drive(0, 0, 16'h0, 1, 'h3FF, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (pc !== 10'h3FF || pc_plus1 !== 10'h000) begin
            n_fail++; $display("FAIL wrap_top: got pc %h plus1 %h expected 3ff 000", pc, pc_plus1);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (pc !== 10'h000) begin
            n_fail++; $display("FAIL wrap_to_zero: got %h expected 000", pc);
        end
`endif
        drive(0, 0, 16'h0, 1, 10, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 16'hFFFE, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (pc !== 10'd9) begin
            n_fail++; $display("FAIL branch_back: got %h expected %h", pc, 10'd9);
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 16'h0005, 1, 'h100, 0, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (pc !== 10'h100) begin
            n_fail++; $display("FAIL jump_over_branch: got %h expected 100", pc);
        end
        n_checks++;
        if (ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL call_with_jump: ras_empty got %b expected 0", ras_empty);
        end
        drive(1, 0, 16'h0, 1, 'h0AA, 0, 0, 1, 0, 1);
        tick();
        n_checks++;
        if (pc !== ADDR_W'(EXC_VEC)) begin
            n_fail++; $display("FAIL exc_over_stall: got %h expected %h", pc, ADDR_W'(EXC_VEC));
        end
        n_checks++;
        if (ras_empty !== 1'b1 || ras_ovf !== 1'b0) begin
            n_fail++; $display("FAIL exc_clears_ras: empty %b ovf %b expected 1 0", ras_empty, ras_ovf);
        end
    endtask

    task automatic test_ras_overflow_underflow();
        drive(0, 0, 16'h0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 16'h0, 1, m_pc + 1, 0, 0, 1, 0, 0);
            tick();
        end
        n_checks++;
        if (pc !== 10'd6 || ras_full !== 1'b1 || ras_ovf !== 1'b1 || ras_unf !== 1'b0) begin
            n_fail++; $display("FAIL five_calls: got pc %h full %b ovf %b unf %b expected 006 1 1 0",
                               pc, ras_full, ras_ovf, ras_unf);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 16'h0, 0, 0, 1, 'h1AA, 0, 1, 0);
            tick();
            n_checks++;
            if (pc !== ADDR_W'(6 - k)) begin
                n_fail++; $display("FAIL ret_%0d: got %h expected %h", k, pc, ADDR_W'(6 - k));
            end
        end
        n_checks++;
        if (ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL ras_drained: ras_empty got %b expected 1", ras_empty);
        end
        drive(0, 0, 16'h0, 0, 0, 1, 'h50, 0, 1, 0);
        tick();
        n_checks++;
        if (pc !== 10'h050 || ras_unf !== 1'b1 || ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL ret_underflow: got pc %h unf %b empty %b expected 050 1 1",
                               pc, ras_unf, ras_empty);
        end
    endtask

    task automatic test_call_ret_same_cycle();
        drive(0, 0, 16'h0, 1, 'h1F, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 16'h0, 1, 'h30, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 16'h0, 0, 0, 1, 'h77, 1, 1, 0);
        tick();
        n_checks++;
        if (pc !== 10'h020 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
            n_fail++; $display("FAIL call_ret_swap: got pc %h empty %b full %b expected 020 0 0",
                               pc, ras_empty, ras_full);
        end
        drive(0, 0, 16'h0, 0, 0, 1, 'h77, 0, 1, 0);
        tick();
        n_checks++;
        if (pc !== 10'h031 || ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL call_ret_new_top: got pc %h empty %b expected 031 1", pc, ras_empty);
        end
    endtask

    task automatic test_bounds();
        drive(0, 0, 16'h0, 1, 'h200, 0, 0, 0, 0, 0);
        tick();
`ifdef PC_BOUNDS_CHECK_EN
        n_checks++;
        if (pc !== ADDR_W'(EXC_VEC) || bound_err !== 1'b1) begin
            n_fail++; $display("FAIL bound_redirect: got pc %h err %b expected %h 1",
                               pc, bound_err, ADDR_W'(EXC_VEC));
        end
        drive(0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (pc !== 10'h000 || bound_err !== 1'b0) begin
            n_fail++; $display("FAIL bound_pulse_end: got pc %h err %b expected 000 0", pc, bound_err);
        end
`else
        n_checks++;
        if (pc !== 10'h200) begin
            n_fail++; $display("FAIL no_bound_check: got %h expected 200", pc);
        end
`endif
    endtask

    task automatic test_async_reset();
        drive(0, 0, 16'h0, 1, 'h40, 0, 0, 1, 0, 0);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (pc !== ADDR_W'(RESET_VEC) || {ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin
            n_fail++; $display("FAIL async_reset: got pc %h flags %b expected %h 1000",
                               pc, {ras_empty, ras_full, ras_ovf, ras_unf}, ADDR_W'(RESET_VEC));
        end
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        n_checks++;
        if (pc !== ADDR_W'(RESET_VEC + 1)) begin
            n_fail++; $display("FAIL post_reset_fetch: got %h expected %h", pc, ADDR_W'(RESET_VEC + 1));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            bit s, br, j, r_jr, c, r, e;
            s    = ($urandom % 8) == 0;
            e    = ($urandom % 40) == 0;
            r_jr = ($urandom % 5) == 0;
            r    = ($urandom % 2) == 0;
            c    = ($urandom % 3) == 0;
            j    = ($urandom % 6) == 0;
            br   = ($urandom % 4) == 0;
            drive(s, br, 16'($urandom), j, int'($urandom % 1024), r_jr,
                  int'($urandom % 1024), c, r, e);
            tick();
            n_checks++;
            if (pc !== ADDR_W'(m_pc)) begin
                n_fail++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, pc, ADDR_W'(m_pc));
            end
            n_checks++;
            if (pc_plus1 !== ADDR_W'((m_pc + 1) & AMASK)) begin
                n_fail++; $display("FAIL rand_pc_plus1[%0d]: got %h expected %h",
                                   i, pc_plus1, ADDR_W'((m_pc + 1) & AMASK));
            end
            n_checks++;
            if (ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == RAS_DEPTH)) begin
                n_fail++; $display("FAIL rand_ras_level[%0d]: got empty %b full %b expected size %0d",
                                   i, ras_empty, ras_full, m_ras.size());
            end
            n_checks++;
            if (ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                n_fail++; $display("FAIL rand_sticky[%0d]: got ovf %b unf %b expected %b %b",
                                   i, ras_ovf, ras_unf, m_ovf, m_unf);
            end
`ifdef PC_BOUNDS_CHECK_EN
            n_checks++;
            if (bound_err !== m_berr) begin
                n_fail++; $display("FAIL rand_bound_err[%0d]: got %b expected %b", i, bound_err, m_berr);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_free_run_stall();
        test_wrap_branch();
        test_priority();
        test_ras_overflow_underflow();
        test_call_ret_same_cycle();
        test_bounds();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
